// File: rtl/div_sqrt_pkg.sv
// Shared FP32 constants, encodings and FSM state for the div/sqrt issue controller.
// Imported by the classifier, the handshake interface and the top level.
package div_sqrt_pkg;

  localparam int C_OP   = 32;
  localparam int C_MANT = 23;
  localparam int C_EXP  = 8;
  localparam int C_PC   = 5;
  localparam int BIAS   = 127;

  localparam logic [C_EXP-1:0] EXP_ALL1 = '1;
  localparam logic [C_EXP+1:0] EXP_OVF  = 10'(2 * BIAS + 1);

  localparam logic [C_OP-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [C_OP-1:0] PINF = 32'h7F80_0000;
  localparam logic [C_OP-1:0] MAXF = 32'h7F7F_FFFF;

  typedef enum logic [1:0] {
    RM_NEAR  = 2'd0,
    RM_TRUNC = 2'd1,
    RM_PINF  = 2'd2,
    RM_MINF  = 2'd3
  } rm_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NORM,
    S_OUT
  } state_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
  } flags_t;

  function automatic logic [C_OP-1:0] sgn_inf(input logic s);
    return {s, PINF[C_OP-2:0]};
  endfunction

  function automatic logic [C_OP-1:0] sgn_zero(input logic s);
    return {s, {(C_OP-1){1'b0}}};
  endfunction

endpackage

// File: rtl/div_sqrt_issue_ctrl_if.sv
// Request/response valid-ready bundle of the div/sqrt issue controller.
// slave is the controller side, master is the requester/consumer side.
interface div_sqrt_issue_ctrl_if;
  import div_sqrt_pkg::*;

  logic              In_valid_SI;
  logic              In_ready_SO;
  logic              Op_div_SI;
  logic [C_OP-1:0]   Operand_a_DI;
  logic [C_OP-1:0]   Operand_b_DI;
  logic [1:0]        Rm_SI;
  logic [C_PC-1:0]   Precision_ctl_SI;
  logic              Out_valid_SO;
  logic              Out_ready_SI;
  logic [C_OP-1:0]   Result_DO;
  logic [3:0]        Flags_DO;

  modport slave (
    input  In_valid_SI,
    input  Op_div_SI,
    input  Operand_a_DI,
    input  Operand_b_DI,
    input  Rm_SI,
    input  Precision_ctl_SI,
    input  Out_ready_SI,
    output In_ready_SO,
    output Out_valid_SO,
    output Result_DO,
    output Flags_DO
  );

  modport master (
    output In_valid_SI,
    output Op_div_SI,
    output Operand_a_DI,
    output Operand_b_DI,
    output Rm_SI,
    output Precision_ctl_SI,
    output Out_ready_SI,
    input  In_ready_SO,
    input  Out_valid_SO,
    input  Result_DO,
    input  Flags_DO
  );

endinterface

// File: rtl/div_sqrt_special_detect.sv
// Combinational classifier for FP32 div/sqrt operands.
// Denormals count as signed zero; special ops never reach the core.
module div_sqrt_special_detect
  import div_sqrt_pkg::*;
(
  input  logic [C_OP-1:0] op_a_i,
  input  logic [C_OP-1:0] op_b_i,
  input  logic            op_div_i,
  output logic            special_o,
  output logic [C_OP-1:0] result_o,
  output flags_t          flags_o
);

  logic              sa, sb, sq;
  logic [C_EXP-1:0]  ea, eb;
  logic [C_MANT-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;

  assign {sa, ea, fa} = op_a_i;
  assign {sb, eb, fb} = op_b_i;
  assign sq = sa ^ sb;

  assign a_zero = (ea == '0);
  assign a_inf  = (ea == EXP_ALL1) && (fa == '0);
  assign a_nan  = (ea == EXP_ALL1) && (fa != '0);
  assign a_snan = a_nan && !fa[C_MANT-1];
  assign b_zero = (eb == '0);
  assign b_inf  = (eb == EXP_ALL1) && (fb == '0);
  assign b_nan  = (eb == EXP_ALL1) && (fb != '0);
  assign b_snan = b_nan && !fb[C_MANT-1];

  // Ordered rule chain: NaN first, then invalid, then inf/zero forms.
  always_comb begin
    special_o = 1'b1;
    result_o  = QNAN;
    flags_o   = '0;
    if (op_div_i) begin
      if (a_nan || b_nan) begin
        flags_o.nv = a_snan || b_snan;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        flags_o.nv = 1'b1;
      end else if (a_zero) begin
        result_o = sgn_zero(sq);
      end else if (a_inf) begin
        result_o = sgn_inf(sq);
      end else if (b_zero) begin
        result_o   = sgn_inf(sq);
        flags_o.dz = 1'b1;
      end else if (b_inf) begin
        result_o = sgn_zero(sq);
      end else begin
        special_o = 1'b0;
        result_o  = '0;
      end
    end else begin
      if (a_nan) begin
        flags_o.nv = a_snan;
      end else if (a_zero) begin
        result_o = sgn_zero(sa);
      end else if (sa) begin
        flags_o.nv = 1'b1;
      end else if (a_inf) begin
        result_o = PINF;
      end else begin
        special_o = 1'b0;
        result_o  = '0;
      end
    end
  end

endmodule

// File: rtl/div_sqrt_issue_ctrl.sv
// Issue/result controller around the iterative div/sqrt mantissa core.
// One op in flight: accept, issue, wait for Done, normalise/pack, present.
module div_sqrt_issue_ctrl
  import div_sqrt_pkg::*;
(
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  div_sqrt_issue_ctrl_if.slave bus,
  output logic              Div_start_SO,
  output logic              Sqrt_start_SO,
  output logic              Start_SO,
  output logic [C_PC-1:0]   Precision_ctl_SO,
  output logic [C_MANT:0]   Mant_a_DO,
  output logic [C_MANT:0]   Mant_b_DO,
  output logic [C_EXP:0]    Exp_a_DO,
  output logic [C_EXP:0]    Exp_b_DO,
  input  logic              Core_ready_SI,
  input  logic              Core_done_SI,
  input  logic [C_MANT:0]   Mant_z_DI,
  input  logic [C_EXP+1:0]  Exp_z_DI
);

  state_e            state_q, state_d;
  logic              op_div_q, sign_q;
  rm_e               rm_q;
  logic [C_PC-1:0]   pc_q;
  logic [C_MANT:0]   mant_a_q, mant_b_q;
  logic [C_EXP:0]    exp_a_q, exp_b_q;
  logic [C_MANT:0]   mant_z_q;
  logic [C_EXP+1:0]  exp_z_q;
  logic [C_OP-1:0]   result_q;
  flags_t            flags_q;

  logic              accept, issue, capture;
  logic              sp;
  logic [C_OP-1:0]   sp_res;
  flags_t            sp_flags;

  logic [C_MANT-1:0] frac_n;
  logic [C_EXP+1:0]  exp_n;
  logic              ovf_inf;
  logic [C_OP-1:0]   norm_res;
  flags_t            norm_flags;

  div_sqrt_special_detect u_special (
    .op_a_i    (bus.Operand_a_DI),
    .op_b_i    (bus.Operand_b_DI),
    .op_div_i  (bus.Op_div_SI),
    .special_o (sp),
    .result_o  (sp_res),
    .flags_o   (sp_flags)
  );

  assign accept  = bus.In_valid_SI && (state_q == S_IDLE);
  assign issue   = (state_q == S_ISSUE) && Core_ready_SI;
  assign capture = (state_q == S_WAIT) && Core_done_SI;

  // State register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = sp ? S_OUT : S_ISSUE;
      S_ISSUE: if (Core_ready_SI) state_d = S_WAIT;
      S_WAIT:  if (Core_done_SI) state_d = S_NORM;
      S_NORM:  state_d = S_OUT;
      S_OUT:   if (bus.Out_ready_SI) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and core start outputs.
  always_comb begin
    bus.In_ready_SO  = (state_q == S_IDLE);
    bus.Out_valid_SO = (state_q == S_OUT);
    Start_SO         = issue;
    Div_start_SO     = issue && op_div_q;
    Sqrt_start_SO    = issue && !op_div_q;
  end

  // Normalise the core mantissa, then range-check and pack.
  always_comb begin
    frac_n = mant_z_q[C_MANT] ? mant_z_q[C_MANT-1:0]
                              : {mant_z_q[C_MANT-2:0], 1'b0};
    exp_n  = mant_z_q[C_MANT] ? exp_z_q : exp_z_q - 10'd1;
    ovf_inf = (rm_q == RM_NEAR)
           || ((rm_q == RM_PINF) && !sign_q)
           || ((rm_q == RM_MINF) && sign_q);
    norm_flags = '0;
    if ($signed(exp_n) >= $signed(EXP_OVF)) begin
      norm_flags.of = 1'b1;
      norm_res = ovf_inf ? sgn_inf(sign_q)
                         : {sign_q, MAXF[C_OP-2:0]};
    end else if ($signed(exp_n) <= $signed(10'd0)) begin
      norm_flags.uf = 1'b1;
      norm_res = sgn_zero(sign_q);
    end else begin
      norm_res = {sign_q, exp_n[C_EXP-1:0], frac_n};
    end
  end

  // Operand latch, core result capture and result register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      op_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rm_q     <= RM_NEAR;
      pc_q     <= '0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      mant_z_q <= '0;
      exp_z_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        op_div_q <= bus.Op_div_SI;
        sign_q   <= bus.Op_div_SI
                 && (bus.Operand_a_DI[31] ^ bus.Operand_b_DI[31]);
        rm_q     <= rm_e'(bus.Rm_SI);
        pc_q     <= bus.Precision_ctl_SI;
        mant_a_q <= {1'b1, bus.Operand_a_DI[C_MANT-1:0]};
        mant_b_q <= {1'b1, bus.Operand_b_DI[C_MANT-1:0]};
        exp_a_q  <= {1'b0, bus.Operand_a_DI[30:C_MANT]};
        exp_b_q  <= {1'b0, bus.Operand_b_DI[30:C_MANT]};
        if (sp) begin
          result_q <= sp_res;
          flags_q  <= sp_flags;
        end
      end
      if (capture) begin
        mant_z_q <= Mant_z_DI;
        exp_z_q  <= Exp_z_DI;
      end
      if (state_q == S_NORM) begin
        result_q <= norm_res;
        flags_q  <= norm_flags;
      end
    end
  end

  assign Precision_ctl_SO = pc_q;
  assign Mant_a_DO        = mant_a_q;
  assign Mant_b_DO        = mant_b_q;
  assign Exp_a_DO         = exp_a_q;
  assign Exp_b_DO         = exp_b_q;
  assign bus.Result_DO    = result_q;
  assign bus.Flags_DO     = flags_q;

endmodule

// File: tb/tb_div_sqrt_issue_ctrl.sv
// Self-checking bench for div_sqrt_issue_ctrl with a behavioural core stub.
// Expected results come from an FP32 rule model kept in the bench.
module tb_div_sqrt_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        div_st, sqrt_st, gen_st;
  logic [4:0]  pc_o;
  logic [23:0] ma_o, mb_o;
  logic [8:0]  xa_o, xb_o;
  logic        core_rdy, core_done;
  logic [23:0] mz;
  logic [9:0]  ez;

  int n_run = 0;
  int n_fail = 0;

  div_sqrt_issue_ctrl_if bus();

  div_sqrt_issue_ctrl dut (
    .Clk_CI           (clk),
    .Rst_RBI          (rst_n),
    .bus              (bus),
    .Div_start_SO     (div_st),
    .Sqrt_start_SO    (sqrt_st),
    .Start_SO         (gen_st),
    .Precision_ctl_SO (pc_o),
    .Mant_a_DO        (ma_o),
    .Mant_b_DO        (mb_o),
    .Exp_a_DO         (xa_o),
    .Exp_b_DO         (xb_o),
    .Core_ready_SI    (core_rdy),
    .Core_done_SI     (core_done),
    .Mant_z_DI        (mz),
    .Exp_z_DI         (ez)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          st_cyc;
    logic        dv, sv, gv;
    logic        st_after;
    logic        any_start;
    logic [23:0] ma, mb;
    logic [8:0]  xa, xb;
    logic [4:0]  pc;
    int          out_cyc;
    logic [31:0] res;
    logic [3:0]  flg;
  } obs_t;

  // 0 zero, 1 normal, 2 inf, 3 qnan, 4 snan
  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0;
    if (x[30:23] != 8'hFF) return 1;
    if (x[22:0] == 23'h0) return 2;
    return x[22] ? 3 : 4;
  endfunction

  function automatic void ref_op(
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    input  logic [23:0] zm,
    input  logic [9:0]  ze,
    output logic        sp,
    output logic [31:0] res,
    output logic [3:0]  flg
  );
    int   ca, cb, e, m;
    logic s, inf_ok;
    ca = cls(a);
    cb = cls(b);
    sp = 1'b1;
    flg = 4'h0;
    res = 32'h7FC00000;
    s = op ? (a[31] ^ b[31]) : 1'b0;
    if (op) begin
      if (ca >= 3 || cb >= 3) flg[3] = (ca == 4 || cb == 4);
      else if ((ca == 0 && cb == 0) || (ca == 2 && cb == 2))
        flg[3] = 1'b1;
      else if (ca == 0) res = {s, 31'h0};
      else if (ca == 2) res = {s, 8'hFF, 23'h0};
      else if (cb == 0) begin
        res = {s, 8'hFF, 23'h0};
        flg[2] = 1'b1;
      end
      else if (cb == 2) res = {s, 31'h0};
      else sp = 1'b0;
    end else begin
      if (ca >= 3) flg[3] = (ca == 4);
      else if (ca == 0) res = {a[31], 31'h0};
      else if (a[31]) flg[3] = 1'b1;
      else if (ca == 2) res = 32'h7F800000;
      else sp = 1'b0;
    end
    if (!sp) begin
      e = int'($signed(ze));
      m = int'(zm);
      if (m < 32'h800000) begin
        m = m * 2;
        e = e - 1;
      end
      if (e >= 255) begin
        flg[1] = 1'b1;
        inf_ok = (rm == 2'd0) || (rm == 2'd2 && !s)
              || (rm == 2'd3 && s);
        res = inf_ok ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
      end else if (e <= 0) begin
        flg[0] = 1'b1;
        res = {s, 31'h0};
      end else begin
        res = {s, e[7:0], m[22:0]};
      end
    end
  endfunction

  task automatic send(input logic op, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] rm,
                      input logic [4:0] pc);
    bus.Op_div_SI        = op;
    bus.Operand_a_DI     = a;
    bus.Operand_b_DI     = b;
    bus.Rm_SI            = rm;
    bus.Precision_ctl_SI = pc;
    bus.In_valid_SI      = 1'b1;
    @(negedge clk);
    bus.In_valid_SI      = 1'b0;
  endtask

  task automatic pulse_done(input logic [23:0] zm, input logic [9:0] ze);
    mz = zm;
    ez = ze;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    mz = $urandom;
    ez = $urandom;
  endtask

  task automatic do_op(input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] rm,
                       input logic [4:0] pc, input logic [23:0] zm,
                       input logic [9:0] ze, input logic sp,
                       output obs_t o);
    o = '{default: 0};
    o.st_cyc = -1;
    o.out_cyc = -1;
    send(op, a, b, rm, pc);
    if (!sp) begin
      for (int i = 0; i < 20; i++) begin
        if (gen_st || div_st || sqrt_st) begin
          o.st_cyc = i;
          break;
        end
        @(negedge clk);
      end
      o.dv = div_st;
      o.sv = sqrt_st;
      o.gv = gen_st;
      o.ma = ma_o;
      o.mb = mb_o;
      o.xa = xa_o;
      o.xb = xb_o;
      o.pc = pc_o;
      @(negedge clk);
      o.st_after = gen_st || div_st || sqrt_st;
      pulse_done(zm, ze);
    end
    for (int i = 0; i < 20; i++) begin
      if (bus.Out_valid_SO) begin
        o.out_cyc = i;
        break;
      end
      if (gen_st || div_st || sqrt_st) o.any_start = 1'b1;
      @(negedge clk);
    end
    o.res = bus.Result_DO;
    o.flg = bus.Flags_DO;
    bus.Out_ready_SI = 1'b1;
    @(negedge clk);
    bus.Out_ready_SI = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_run++;
    if (bus.Out_valid_SO !== 1'b0 || bus.Result_DO !== 32'h0
        || bus.Flags_DO !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b res=%h flg=%h want 0/0/0",
               bus.Out_valid_SO, bus.Result_DO, bus.Flags_DO);
    end
    n_run++;
    if ({gen_st, div_st, sqrt_st} !== 3'b0 || ma_o !== 24'h0
        || pc_o !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_core: st=%b ma=%h pc=%h want 0",
               {gen_st, div_st, sqrt_st}, ma_o, pc_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (bus.In_ready_SO !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", bus.In_ready_SO);
    end
  endtask

  task automatic test_div_basic();
    obs_t o;
    do_op(1'b1, 32'h40C00000, 32'h40000000, 2'd0, 5'h17,
          24'hC00000, 10'h080, 1'b0, o);
    n_run++;
    if (o.st_cyc !== 0 || {o.gv, o.dv, o.sv} !== 3'b110
        || o.st_after !== 1'b0) begin
      n_fail++;
      $display("FAIL div_start: cyc=%0d gds=%b after=%b want 0/110/0",
               o.st_cyc, {o.gv, o.dv, o.sv}, o.st_after);
    end
    n_run++;
    if (o.ma !== 24'hC00000 || o.mb !== 24'h800000
        || o.xa !== 9'h081 || o.xb !== 9'h080 || o.pc !== 5'h17) begin
      n_fail++;
      $display("FAIL div_operands: %h %h %h %h %h want c00000 800000 81 80 17",
               o.ma, o.mb, o.xa, o.xb, o.pc);
    end
    n_run++;
    if (o.out_cyc !== 1 || o.res !== 32'h40400000 || o.flg !== 4'h0) begin
      n_fail++;
      $display("FAIL div_result: cyc=%0d res=%h flg=%h want 1/40400000/0",
               o.out_cyc, o.res, o.flg);
    end
  endtask

  task automatic test_sqrt_basic();
    obs_t o;
    do_op(1'b0, 32'h40800000, 32'h12345678, 2'd1, 5'h03,
          24'h800000, 10'h080, 1'b0, o);
    n_run++;
    if ({o.gv, o.dv, o.sv} !== 3'b101 || o.st_after !== 1'b0) begin
      n_fail++;
      $display("FAIL sqrt_start: gds=%b after=%b want 101/0",
               {o.gv, o.dv, o.sv}, o.st_after);
    end
    n_run++;
    if (o.res !== 32'h40000000 || o.flg !== 4'h0) begin
      n_fail++;
      $display("FAIL sqrt_result: res=%h flg=%h want 40000000/0",
               o.res, o.flg);
    end
  endtask

  task automatic test_special();
    obs_t o;
    do_op(1'b1, 32'h3F800000, 32'h00000000, 2'd0, 5'h0,
          24'h0, 10'h0, 1'b1, o);
    n_run++;
    if (o.out_cyc !== 0 || o.any_start !== 1'b0
        || o.res !== 32'h7F800000 || o.flg !== 4'b0100) begin
      n_fail++;
      $display("FAIL div_by_zero: cyc=%0d st=%b res=%h flg=%b want 0/0/7f800000/0100",
               o.out_cyc, o.any_start, o.res, o.flg);
    end
    do_op(1'b0, 32'hBF800000, 32'h0, 2'd0, 5'h0,
          24'h0, 10'h0, 1'b1, o);
    n_run++;
    if (o.out_cyc !== 0 || o.any_start !== 1'b0
        || o.res !== 32'h7FC00000 || o.flg !== 4'b1000) begin
      n_fail++;
      $display("FAIL sqrt_neg: cyc=%0d st=%b res=%h flg=%b want 0/0/7fc00000/1000",
               o.out_cyc, o.any_start, o.res, o.flg);
    end
  endtask

  task automatic test_range();
    obs_t o;
    do_op(1'b1, 32'h3F800000, 32'h3F800000, 2'd0, 5'h0,
          24'h800000, 10'h100, 1'b0, o);
    n_run++;
    if (o.res !== 32'h7F800000 || o.flg !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_near: res=%h flg=%b want 7f800000/0010",
               o.res, o.flg);
    end
    do_op(1'b1, 32'h3F800000, 32'h3F800000, 2'd1, 5'h0,
          24'h800000, 10'h100, 1'b0, o);
    n_run++;
    if (o.res !== 32'h7F7FFFFF || o.flg !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_trunc: res=%h flg=%b want 7f7fffff/0010",
               o.res, o.flg);
    end
    do_op(1'b1, 32'h3F800000, 32'h3F800000, 2'd0, 5'h0,
          24'h800000, 10'h3F0, 1'b0, o);
    n_run++;
    if (o.res !== 32'h00000000 || o.flg !== 4'b0001) begin
      n_fail++;
      $display("FAIL unf_flush: res=%h flg=%b want 00000000/0001",
               o.res, o.flg);
    end
  endtask

  task automatic test_core_stall();
    logic bad;
    core_rdy = 1'b0;
    send(1'b1, 32'h40C00000, 32'h40000000, 2'd0, 5'h0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gen_st || div_st || sqrt_st) bad = 1'b1;
      @(negedge clk);
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_start: start seen=%b want 0", bad);
    end
    core_rdy = 1'b1;
    #1;
    n_run++;
    if (gen_st !== 1'b1 || div_st !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_start: gen=%b div=%b want 1/1", gen_st, div_st);
    end
    @(negedge clk);
    n_run++;
    if (gen_st !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_pulse_len: gen=%b want 0", gen_st);
    end
    pulse_done(24'hC00000, 10'h080);
    @(negedge clk);
    n_run++;
    if (bus.Out_valid_SO !== 1'b1 || bus.Result_DO !== 32'h40400000) begin
      n_fail++;
      $display("FAIL stall_result: v=%b res=%h want 1/40400000",
               bus.Out_valid_SO, bus.Result_DO);
    end
    bus.Out_ready_SI = 1'b1;
    @(negedge clk);
    bus.Out_ready_SI = 1'b0;
  endtask

  task automatic test_out_stall();
    logic bad;
    send(1'b1, 32'hC0000000, 32'h00000000, 2'd0, 5'h0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.Out_valid_SO !== 1'b1 || bus.In_ready_SO !== 1'b0
          || bus.Result_DO !== 32'hFF800000
          || bus.Flags_DO !== 4'b0100) bad = 1'b1;
      @(negedge clk);
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL out_stall_hold: v=%b rdy=%b res=%h want 1/0/ff800000",
               bus.Out_valid_SO, bus.In_ready_SO, bus.Result_DO);
    end
    bus.Out_ready_SI = 1'b1;
    @(negedge clk);
    bus.Out_ready_SI = 1'b0;
    n_run++;
    if (bus.Out_valid_SO !== 1'b0 || bus.In_ready_SO !== 1'b1) begin
      n_fail++;
      $display("FAIL out_stall_release: v=%b rdy=%b want 0/1",
               bus.Out_valid_SO, bus.In_ready_SO);
    end
  endtask

  task automatic test_spurious_done();
    logic bad;
    pulse_done(24'hC00000, 10'h080);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.Out_valid_SO !== 1'b0 || bus.In_ready_SO !== 1'b1)
        bad = 1'b1;
      @(negedge clk);
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_done: v=%b rdy=%b want 0/1",
               bus.Out_valid_SO, bus.In_ready_SO);
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    logic bad;
    send(1'b1, 32'h40C00000, 32'h40000000, 2'd0, 5'h1F);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_run++;
    if (bus.Out_valid_SO !== 1'b0 || bus.Result_DO !== 32'h0
        || ma_o !== 24'h0 || pc_o !== 5'h0 || bus.In_ready_SO !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_clear: v=%b res=%h ma=%h pc=%h rdy=%b want 0/0/0/0/1",
               bus.Out_valid_SO, bus.Result_DO, ma_o, pc_o, bus.In_ready_SO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_done(24'hC00000, 10'h080);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.Out_valid_SO !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_run++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_late_done: out_valid seen=%b want 0", bad);
    end
    do_op(1'b1, 32'h40C00000, 32'h40000000, 2'd0, 5'h0,
          24'hC00000, 10'h080, 1'b0, o);
    n_run++;
    if (o.out_cyc !== 1 || o.res !== 32'h40400000 || o.flg !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_next_op: cyc=%0d res=%h flg=%h want 1/40400000/0",
               o.out_cyc, o.res, o.flg);
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    logic        s;
    s = 1'($urandom);
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 1'b1, r[21:0]};
      3: return {s, 8'hFF, 1'b0, r[21:1], 1'b1};
      4: return {s, 8'h00, r[22:0]};
      default: return {s, 8'($urandom_range(1, 254)), r[22:0]};
    endcase
  endfunction

  task automatic test_random();
    obs_t        o;
    logic        op, sp;
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    logic [1:0]  rm;
    logic [4:0]  pc;
    logic [23:0] zm;
    logic [9:0]  ze;
    logic [31:0] r;
    for (int k = 0; k < 40; k++) begin
      op = 1'($urandom);
      a  = rand_fp();
      b  = rand_fp();
      rm = 2'($urandom);
      pc = 5'($urandom);
      r  = $urandom;
      zm = r[31] ? {1'b1, r[22:0]} : {2'b01, r[21:0]};
      ze = 10'($urandom_range(0, 299) - 20);
      ref_op(op, a, b, rm, zm, ze, sp, er, ef);
      do_op(op, a, b, rm, pc, zm, ze, sp, o);
      n_run++;
      if (o.res !== er || o.flg !== ef) begin
        n_fail++;
        $display("FAIL rnd_result[%0d]: op=%b a=%h b=%h rm=%0d res=%h flg=%b want %h/%b",
                 k, op, a, b, rm, o.res, o.flg, er, ef);
      end
      if (sp) begin
        n_run++;
        if (o.out_cyc !== 0 || o.any_start !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_special[%0d]: cyc=%0d st=%b want 0/0",
                   k, o.out_cyc, o.any_start);
        end
      end else begin
        n_run++;
        if (o.st_cyc !== 0 || {o.gv, o.dv, o.sv} !== {1'b1, op, !op}
            || o.st_after !== 1'b0 || o.out_cyc !== 1) begin
          n_fail++;
          $display("FAIL rnd_timing[%0d]: st=%0d gds=%b after=%b out=%0d",
                   k, o.st_cyc, {o.gv, o.dv, o.sv}, o.st_after, o.out_cyc);
        end
        n_run++;
        if (o.ma !== {1'b1, a[22:0]} || o.mb !== {1'b1, b[22:0]}
            || o.xa !== {1'b0, a[30:23]} || o.xb !== {1'b0, b[30:23]}
            || o.pc !== pc) begin
          n_fail++;
          $display("FAIL rnd_operands[%0d]: ma=%h mb=%h xa=%h xb=%h pc=%h",
                   k, o.ma, o.mb, o.xa, o.xb, o.pc);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    core_rdy = 1'b1;
    core_done = 1'b0;
    mz = '0;
    ez = '0;
    bus.In_valid_SI = 1'b0;
    bus.Op_div_SI = 1'b0;
    bus.Operand_a_DI = '0;
    bus.Operand_b_DI = '0;
    bus.Rm_SI = '0;
    bus.Precision_ctl_SI = '0;
    bus.Out_ready_SI = 1'b0;
    test_reset();
    test_div_basic();
    test_sqrt_basic();
    test_special();
    test_range();
    test_core_stall();
    test_out_stall();
    test_spurious_done();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sqrt_issue_ctrl.md
Name: div_sqrt_issue_ctrl

Overview:
- Initiator and result consumer for the iterative non-restoring div/sqrt mantissa core (nrbd_nrsc_tp interface).
- Accepts FP32 operand pairs over a valid/ready handshake, unpacks them and resolves special cases locally.
- Issues a start pulse to the core, waits for Done, then normalises, range-checks and packs the result.
- Presents the packed result and flags over a valid/ready handshake; one operation in flight.

Parameters:
C_OP, 32, operand/result width (FP32 only)
C_MANT, 23, fraction bits
C_EXP, 8, exponent bits
C_PC, 5, precision-control width forwarded to core

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
In_valid_SI  in  1  operation request valid
In_ready_SO  out  1  block can accept a request
Op_div_SI  in  1  1=divide a/b, 0=sqrt a
Operand_a_DI  in  32  FP32 operand a
Operand_b_DI  in  32  FP32 operand b (ignored for sqrt)
Rm_SI  in  2  rounding mode: 0 nearest, 1 trunc, 2 +inf, 3 -inf
Precision_ctl_SI  in  5  precision control, latched with operands
Div_start_SO  out  1  core divide start (1-cycle pulse)
Sqrt_start_SO  out  1  core sqrt start (1-cycle pulse)
Start_SO  out  1  core generic start (1-cycle pulse)
Precision_ctl_SO  out  5  latched precision control to core
Mant_a_DO  out  24  {hidden 1, frac a}
Mant_b_DO  out  24  {hidden 1, frac b}
Exp_a_DO  out  9  {0, exp a}
Exp_b_DO  out  9  {0, exp b}
Core_ready_SI  in  1  core idle
Core_done_SI  in  1  core result valid (1 cycle)
Mant_z_DI  in  24  core pre-normalised mantissa
Exp_z_DI  in  10  core biased exponent, two's complement
Out_valid_SO  out  1  result valid
Out_ready_SI  in  1  downstream accepts result
Result_DO  out  32  packed FP32 result
Flags_DO  out  4  {NV, DZ, OF, UF}

Behaviour:
- Reset: state IDLE; all registered outputs 0; In_ready_SO=1 after release. Reset mid-operation aborts; any later Core_done_SI is ignored.
- States:
  - IDLE: In_ready_SO=1. An accept (In_valid_SI & In_ready_SO) latches operands, Rm, Precision_ctl and op. Go to OUT if the op is special, else ISSUE.
  - ISSUE: when Core_ready_SI=1, pulse Start_SO and the matching Div/Sqrt_start_SO for exactly one cycle, then go to WAIT. Otherwise hold in ISSUE.
  - WAIT: on Core_done_SI, capture Mant_z/Exp_z and go to NORM. Done in any other state is ignored.
  - NORM: one cycle. Compute and register Result/Flags, then go to OUT.
  - OUT: Out_valid_SO=1. Result_DO/Flags_DO are stable until Out_ready_SI=1, then go to IDLE.
- Overlap: In_ready_SO=0 in every state except IDLE. There is no overlap of accept and output.
- Latency:
  - Special case: Out_valid_SO 1 cycle after accept.
  - Normal case: Start pulse 1 cycle after accept (core ready); Out_valid_SO 2 cycles after Done.
- Mant_*_DO, Exp_*_DO and Precision_ctl_SO are held from accept until leaving WAIT.
- Denormal inputs (exp=0) are treated as signed zero.
- Special cases (core not started):
  - Any NaN → 0x7FC00000; NV set if any input is a signalling NaN.
  - div 0/0 or inf/inf → 0x7FC00000, NV.
  - div x/0 (x finite, nonzero) → signed inf, DZ.
  - div inf/x → signed inf. div 0/x or x/inf → signed zero.
  - sqrt of a negative nonzero value (including -inf) → 0x7FC00000, NV.
  - sqrt ±0 → ±0. sqrt +inf → +inf.
- Sign: div = sa^sb; sqrt = 0.
- Normalisation:
  - If Mant_z[23]=0: mantissa <<1 and exponent −1.
  - Final exponent E is a 10-bit signed value.
  - Frac = normalised Mant_z[22:0]; no further rounding (the core result is truncated).
- Range checks:
  - E ≥ 255 → OF. Result is inf if Rm=nearest, or Rm is directed toward the sign. It is max-finite (exp 0xFE, frac all-ones) for trunc, or when directed away from the sign.
  - E ≤ 0 → UF; result is signed zero (flush).
- Flags_DO is all-zero except as set above.

Decomposition:
- Package div_sqrt_pkg holds the FP32 field widths, bias, rounding-mode encodings, canonical NaN and inf constants, and the state enum.
- Sub-module div_sqrt_special_detect: combinational classifier taking the two operands and op, giving special flag, special result and special flags.
- Normalise/pack stays in the top level.

Test Plan:
- 6.0/2.0 (0x40C00000/0x40000000), core returns Mant_z=0x C00000, Exp_z=0x080 → Result 0x40400000, Flags 0. Start pulse is exactly 1 cycle.
- sqrt 4.0 (0x40800000), core returns 0x800000, Exp 0x080 → 0x40000000. Only Sqrt_start_SO pulses.
- 1.0/0.0 → 0x7F800000, DZ, Out_valid 1 cycle after accept, no Start pulse. sqrt(-1.0) → 0x7FC00000, NV.
- Core returns Exp_z=0x100, sign 0: Rm=0 → 0x7F800000 OF; Rm=1 → 0x7F7FFFFF OF. Exp_z=0x3F0 → 0x00000000 UF.
- Core_ready_SI low 4 cycles in ISSUE → no start until it rises. Out_ready_SI low 5 cycles → Result stable, In_ready_SO=0. A spurious Core_done_SI in IDLE is ignored.
- Rst_RBI asserted mid-WAIT → immediate IDLE, outputs 0. A later Done produces no Out_valid; the next operation completes normally.
